// File: rtl/aes_pkg.sv
// Shared AES field constants: polynomials, affine constant and the basis change
// between the AES polynomial basis and the GF((2^4)^2) tower used by the S-box.
package aes_pkg;

   typedef logic [7:0]      byte_t;
   typedef logic [3:0]      nibble_t;
   typedef logic [7:0][7:0] bit_matrix_t;

   localparam logic [8:0] AES_POLY  = 9'h11B;
   localparam byte_t      AFFINE_C  = 8'h63;

   // Tower: GF(2^4) = GF(2)[t]/(t^4+t+1), GF(2^8) = GF(2^4)[y]/(y^2+y+LAMBDA).
   // An element is stored as {high nibble = y coefficient, low nibble}.
   localparam nibble_t    GF16_RED    = 4'h3;
   localparam nibble_t    GF16_LAMBDA = 4'hC;

   // Row r selects the input bits XORed into output bit r.
   // ISO_MAP sends AES 0x02 to the tower root of x^8+x^4+x^3+x+1 (0x40);
   // ISO_INV is its inverse (tower t -> 0xE1, y -> 0xA2).
   localparam bit_matrix_t ISO_MAP = {8'hA0, 8'h72, 8'hAC, 8'hDC,
                                      8'h18, 8'h1C, 8'hFC, 8'h5D};
   localparam bit_matrix_t ISO_INV = {8'h92, 8'h86, 8'h12, 8'hA4,
                                      8'hAC, 8'h0C, 8'h70, 8'h83};

   function automatic byte_t mat_mul(input bit_matrix_t m, input byte_t v);
      byte_t y;
      y = '0;
      for (int r = 0; r < 8; r++) begin
         y[r] = ^(m[r] & v);
      end
      return y;
   endfunction

endpackage

// File: rtl/sbox_comb.sv
// Combinational forward AES S-box: tower-field inversion followed by the affine
// transform. No state; reusable wherever a byte substitution is needed.
module sbox_comb
   import aes_pkg::*;
(
   input  logic [7:0] in,
   output logic [7:0] out
);

   function automatic nibble_t gf16_mul(input nibble_t a, input nibble_t b);
      nibble_t acc;
      nibble_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end
         sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF16_RED : 4'h0);
      end
      return acc;
   endfunction

   function automatic nibble_t gf16_inv(input nibble_t a);
      nibble_t r;
      case (a)
         4'h0:    r = 4'h0;
         4'h1:    r = 4'h1;
         4'h2:    r = 4'h9;
         4'h3:    r = 4'hE;
         4'h4:    r = 4'hD;
         4'h5:    r = 4'hB;
         4'h6:    r = 4'h7;
         4'h7:    r = 4'h6;
         4'h8:    r = 4'hF;
         4'h9:    r = 4'h2;
         4'hA:    r = 4'hC;
         4'hB:    r = 4'h5;
         4'hC:    r = 4'hA;
         4'hD:    r = 4'h4;
         4'hE:    r = 4'h3;
         default: r = 4'h8;
      endcase
      return r;
   endfunction

   function automatic byte_t affine(input byte_t b);
      return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]}
               ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ AFFINE_C;
   endfunction

   byte_t   iso;
   nibble_t ah;
   nibble_t al;
   nibble_t norm;
   nibble_t norm_inv;
   nibble_t inv_h;
   nibble_t inv_l;
   byte_t   inv_aes;

   assign iso = mat_mul(ISO_MAP, in);
   assign ah  = iso[7:4];
   assign al  = iso[3:0];

   // (ah*y + al)^-1 = (ah*y + ah + al) / N, N = ah^2*LAMBDA + ah*al + al^2.
   // N is zero only for the zero element, which then maps back to zero.
   assign norm     = gf16_mul(gf16_mul(ah, ah), GF16_LAMBDA)
                   ^ gf16_mul(ah, al) ^ gf16_mul(al, al);
   assign norm_inv = gf16_inv(norm);
   assign inv_h    = gf16_mul(ah, norm_inv);
   assign inv_l    = gf16_mul(ah ^ al, norm_inv);

   assign inv_aes = mat_mul(ISO_INV, {inv_h, inv_l});
   assign out     = affine(inv_aes);

endmodule

// File: rtl/sbox.sv
// Registered AES S-box: one byte substituted per cycle, one cycle of latency.
module sbox
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in,
   output logic [7:0] out
);

   byte_t sub_p0;

   sbox_comb u_core (
      .in  (in),
      .out (sub_p0)
   );

   // stage p0 -> registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= sub_p0;
      end
   end

endmodule

// File: tb/tb_sbox.sv
// Directed bench for the registered AES S-box: reset behaviour, known vectors,
// full sweep against the FIPS-197 table, back-to-back toggling.
module tb_sbox;

   logic       clk;
   logic       rst_n;
   logic [7:0] in;
   logic [7:0] out;

   int checks = 0;
   int errors = 0;

   logic [7:0] golden [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   sbox dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b1;
      in    = 8'h00;
      #1 rst_n = 1'b0;
      in = 8'h53;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold edge %0d: out=%02h expected=00", k, out);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out !== 8'hed) begin
         errors++;
         $display("FAIL reset_release: out=%02h expected=ed", out);
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 8'h00) begin
         errors++;
         $display("FAIL async_assert: out=%02h expected=00", out);
      end
      #2 rst_n = 1'b1;
      #1;
      checks++;
      if (out !== 8'h00) begin
         errors++;
         $display("FAIL async_hold_until_edge: out=%02h expected=00", out);
      end
      @(posedge clk); #1;
      checks++;
      if (out !== 8'hed) begin
         errors++;
         $display("FAIL async_first_edge: out=%02h expected=ed", out);
      end
   endtask

   task automatic test_known_vectors();
      logic [7:0] kv_in  [7] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h53, 8'h80, 8'hff};
      logic [7:0] kv_out [7] = '{8'h63, 8'h7c, 8'hca, 8'h82, 8'hed, 8'hcd, 8'h16};
      for (int k = 0; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k > 0) begin
            checks++;
            if (out !== kv_out[k-1]) begin
               errors++;
               $display("FAIL known_vector in=%02h: out=%02h expected=%02h",
                        kv_in[k-1], out, kv_out[k-1]);
            end
         end
         if (k < 7) in = kv_in[k];
      end
   endtask

   task automatic test_sweep();
      logic seen [256];
      int   distinct;
      for (int j = 0; j < 256; j++) seen[j] = 1'b0;
      distinct = 0;
      for (int i = 0; i <= 256; i++) begin
         @(posedge clk); #1;
         if (i > 0) begin
            checks++;
            if (out !== golden[i-1]) begin
               errors++;
               $display("FAIL sweep in=%02h: out=%02h expected=%02h", i - 1, out, golden[i-1]);
            end
            if (!seen[out]) distinct++;
            seen[out] = 1'b1;
         end
         if (i < 256) begin
            in = i[7:0];
            if (i == 8'h80) begin
               #2 rst_n = 1'b0;
               #1;
               checks++;
               if (out !== 8'h00) begin
                  errors++;
                  $display("FAIL midstream_reset_low: out=%02h expected=00", out);
               end
               #2 rst_n = 1'b1;
               #1;
               checks++;
               if (out !== 8'h00) begin
                  errors++;
                  $display("FAIL midstream_reset_released: out=%02h expected=00", out);
               end
            end
         end
      end
      checks++;
      if (distinct != 256) begin
         errors++;
         $display("FAIL sweep_permutation: distinct=%0d expected=256", distinct);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] prev;
      prev = 8'h00;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k > 0) begin
            checks++;
            if (out !== ((prev == 8'h00) ? 8'h63 : 8'h16)) begin
               errors++;
               $display("FAIL back_to_back cycle %0d in=%02h: out=%02h expected=%02h",
                        k, prev, out, (prev == 8'h00) ? 8'h63 : 8'h16);
            end
         end
         prev = (k % 2 == 0) ? 8'h00 : 8'hff;
         in   = prev;
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_known_vectors();
      test_sweep();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
